// File: rtl/aes_pkg.sv
// Shared AES definitions for the encipher round engine: key length codes,
// round counts, controller states and the ShiftRows/MixColumns helpers.
package aes_pkg;

    localparam logic [1:0] KEYLEN_128  = 2'b00;
    localparam logic [1:0] KEYLEN_192  = 2'b01;
    localparam logic [1:0] KEYLEN_256  = 2'b10;
    localparam logic [1:0] KEYLEN_RSVD = 2'b11;

    localparam logic [3:0] NR_128 = 4'ha;
    localparam logic [3:0] NR_192 = 4'hc;
    localparam logic [3:0] NR_256 = 4'he;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_SBOX,
        ST_MAIN
    } ctrl_state_t;

    function automatic logic [3:0] nr_of(input logic [1:0] keylen);
        case (keylen)
            KEYLEN_128: return NR_128;
            KEYLEN_192: return NR_192;
            KEYLEN_256: return NR_256;
            default:    return NR_128;
        endcase
    endfunction

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    // One column of MixColumns; byte 0 of the column sits in bits 31:24.
    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
                b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] s);
        return {mixw(s[127:96]), mixw(s[95:64]), mixw(s[63:32]), mixw(s[31:0])};
    endfunction

    // Row r of the state rotates left by r columns.
    function automatic logic [127:0] shiftrows(input logic [127:0] s);
        logic [31:0] w0, w1, w2, w3;
        w0 = s[127:96];
        w1 = s[95:64];
        w2 = s[63:32];
        w3 = s[31:0];
        return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
                w1[31:24], w2[23:16], w3[15:8], w0[7:0],
                w2[31:24], w3[23:16], w0[15:8], w1[7:0],
                w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
    endfunction

endpackage

// File: rtl/aes_enc_round_dp.sv
// Combinational round datapath: candidate next states for the initial,
// main and final rounds. SubBytes is done outside through the S-box lanes.
module aes_enc_round_dp
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] block_msg,
    input  logic [127:0] round_key,
    output logic [127:0] init_block,
    output logic [127:0] main_block,
    output logic [127:0] final_block
);

    logic [127:0] shifted;

    // Build the three round results from the current state and key.
    always_comb begin
        shifted     = shiftrows(state);
        init_block  = block_msg ^ round_key;
        main_block  = mixcolumns(shifted) ^ round_key;
        final_block = shifted ^ round_key;
    end

endmodule

// File: rtl/aes_enc_round_engine.sv
// AES encipher round engine: owns the state register, round sequencing,
// S-box lane multiplexing and abort / done / keylen error reporting.
module aes_enc_round_engine
    import aes_pkg::*;
#(
    parameter int SBOX_LANES = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [1:0]              keylen,
    output logic [3:0]              round,
    input  logic [127:0]            round_key,
    output logic [32*SBOX_LANES-1:0] sboxw,
    input  logic [32*SBOX_LANES-1:0] new_sboxw,
    input  logic [127:0]            block_msg,
    output logic [127:0]            new_block,
    output logic                    ready,
    output logic                    done,
    output logic                    keylen_err
);

    localparam int         SUB_CYCLES = 4 / SBOX_LANES;
    localparam logic [1:0] SUB_LAST   = 2'(SUB_CYCLES - 1);

    ctrl_state_t  state_q, state_d;
    logic [1:0]   keylen_q, keylen_d;
    logic [1:0]   sub_cnt, sub_d;
    logic [3:0]   round_d;
    logic [127:0] block_d;
    logic         ready_d, done_d, err_d;
    logic [3:0]   nr;
    logic [127:0] init_block, main_block, final_block;
    logic [31:0]  cur_word [4];
    logic [1:0]   lane_idx [SBOX_LANES];

    assign nr = nr_of(keylen_q);

    aes_enc_round_dp u_dp (
        .state       (new_block),
        .block_msg   (block_msg),
        .round_key   (round_key),
        .init_block  (init_block),
        .main_block  (main_block),
        .final_block (final_block)
    );

    // Split the state register into words, w0 being the top 32 bits.
    always_comb begin
        for (int w = 0; w < 4; w++) begin
            cur_word[w] = new_block[127-32*w -: 32];
        end
    end

    // Each lane serves word c*SBOX_LANES+k in sub-cycle c; idle lanes drive zero.
    for (genvar k = 0; k < SBOX_LANES; k++) begin : g_lane
        assign lane_idx[k] = 2'(32'(sub_cnt) * SBOX_LANES + k);
        assign sboxw[32*k +: 32] = (state_q == ST_SBOX) ? cur_word[lane_idx[k]] : 32'd0;
    end

    // Next-state and datapath register decode; abort outranks every other request.
    always_comb begin
        state_d  = state_q;
        keylen_d = keylen_q;
        sub_d    = sub_cnt;
        round_d  = round;
        block_d  = new_block;
        ready_d  = ready;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (abort) begin
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                round_d = 4'd0;
                sub_d   = 2'd0;
                block_d = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (keylen == KEYLEN_RSVD) begin
                            err_d = 1'b1;
                        end else begin
                            keylen_d = keylen;
                            round_d  = 4'd0;
                            ready_d  = 1'b0;
                            state_d  = ST_INIT;
                        end
                    end
                end
                ST_INIT: begin
                    block_d = init_block;
                    round_d = round + 4'd1;
                    sub_d   = 2'd0;
                    state_d = ST_SBOX;
                end
                ST_SBOX: begin
                    for (int w = 0; w < 4; w++) begin
                        for (int k = 0; k < SBOX_LANES; k++) begin
                            if (lane_idx[k] == 2'(w)) begin
                                block_d[127-32*w -: 32] = new_sboxw[32*k +: 32];
                            end
                        end
                    end
                    if (sub_cnt == SUB_LAST) begin
                        sub_d   = 2'd0;
                        state_d = ST_MAIN;
                    end else begin
                        sub_d = sub_cnt + 2'd1;
                    end
                end
                ST_MAIN: begin
                    if (round < nr) begin
                        block_d = main_block;
                        round_d = round + 4'd1;
                        sub_d   = 2'd0;
                        state_d = ST_SBOX;
                    end else begin
                        block_d = final_block;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            keylen_q   <= KEYLEN_128;
            sub_cnt    <= 2'd0;
            round      <= 4'd0;
            new_block  <= '0;
            ready      <= 1'b1;
            done       <= 1'b0;
            keylen_err <= 1'b0;
        end else begin
            state_q    <= state_d;
            keylen_q   <= keylen_d;
            sub_cnt    <= sub_d;
            round      <= round_d;
            new_block  <= block_d;
            ready      <= ready_d;
            done       <= done_d;
            keylen_err <= err_d;
        end
    end

endmodule

// File: tb/tb_aes_enc_round_engine.sv
// Bench for the AES round engine: one instance per S-box lane count, each
// with its own key schedule / S-box return paths, stimulus and scoreboard.
module tb_aes_enc_round_engine;

    typedef logic [14:0][127:0] rk_set_t;
    typedef struct {
        logic [127:0] ct;
        int unsigned  due;
    } exp_t;

    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic        clk = 1'b0;
    logic        reset_n;
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  sbox_tab [256];
    bit          fin [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check_output(input int lanes, input string name,
                                         input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL L%0d %s: got %h expected %h", lanes, name, act, req);
        end
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic int nr_for(input logic [1:0] kl);
        case (kl)
            2'b01:   return 12;
            2'b10:   return 14;
            default: return 10;
        endcase
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    function automatic rk_set_t expand_key(input logic [255:0] key, input logic [1:0] kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nk, nr;
        rk_set_t     rk;
        nr = nr_for(kl);
        nk = nr - 6;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        rk = '0;
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    // Byte-array reference cipher: s[4c+r] is row r of column c.
    function automatic logic [127:0] encrypt(input logic [255:0] key, input logic [1:0] kl,
                                             input logic [127:0] pt);
        rk_set_t      rk;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] res;
        int           nr;
        rk = expand_key(key, kl);
        nr = nr_for(kl);
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c+row] = s[4*((c+row)%4)+row];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    if (r < nr)
                        s[4*c+row] = gmul(8'h02, t[4*c+row]) ^ gmul(8'h03, t[4*c+(row+1)%4])
                                   ^ t[4*c+(row+2)%4] ^ t[4*c+(row+3)%4];
                    else
                        s[4*c+row] = t[4*c+row];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    initial begin
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int LANES = 1 << g;
        localparam int SUBS  = 4 / LANES;

        logic                   start, abort;
        logic [1:0]             keylen;
        logic [3:0]             round;
        logic [127:0]           round_key, block_msg, new_block;
        logic [32*LANES-1:0]    sboxw, new_sboxw;
        logic                   ready, done, keylen_err;
        rk_set_t                rk_cur;
        exp_t                   exp_q [$];
        exp_t                   popped;
        logic [127:0]           hold_val;
        int unsigned            last_due, last_start;

        aes_enc_round_engine #(.SBOX_LANES(LANES)) dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .start      (start),
            .abort      (abort),
            .keylen     (keylen),
            .round      (round),
            .round_key  (round_key),
            .sboxw      (sboxw),
            .new_sboxw  (new_sboxw),
            .block_msg  (block_msg),
            .new_block  (new_block),
            .ready      (ready),
            .done       (done),
            .keylen_err (keylen_err)
        );

        always_comb begin
            round_key = (round <= 4'd14) ? rk_cur[round] : 128'h0;
        end

        always_comb begin
            new_sboxw = '0;
            for (int k = 0; k < LANES; k++)
                new_sboxw[32*k +: 32] = {sbox_tab[sboxw[32*k+24 +: 8]], sbox_tab[sboxw[32*k+16 +: 8]],
                                         sbox_tab[sboxw[32*k+8 +: 8]],  sbox_tab[sboxw[32*k +: 8]]};
        end

        // Scoreboard monitor: pops one expected ciphertext per done pulse.
        initial forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                if (done === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check_output(LANES, "unexpected done", 128'(done), 128'd0);
                    end else begin
                        popped = exp_q.pop_front();
                        check_output(LANES, "ciphertext", new_block, popped.ct);
                        check_output(LANES, "done cycle", 128'(cyc), 128'(popped.due));
                        check_output(LANES, "ready at done", 128'(ready), 128'd1);
                        hold_val = popped.ct;
                    end
                end else if (exp_q.size() != 0 && cyc >= exp_q[0].due) begin
                    check_output(LANES, "done missing", 128'(done), 128'd1);
                    popped = exp_q.pop_front();
                end
                if (ready === 1'b1) begin
                    check_output(LANES, "idle hold", new_block, hold_val);
                    check_output(LANES, "idle sboxw", 128'(sboxw), 128'd0);
                end else begin
                    check_output(LANES, "busy keylen_err", 128'(keylen_err), 128'd0);
                end
            end
        end

        task automatic apply_stimulus(input logic [255:0] key, input logic [1:0] kl,
                                      input logic [127:0] pt, input logic [127:0] ct);
            exp_t e;
            rk_cur     = expand_key(key, kl);
            block_msg  = pt;
            keylen     = kl;
            start      = 1'b1;
            e.ct       = ct;
            e.due      = cyc + 2 + nr_for(kl) * (SUBS + 1);
            last_due   = e.due;
            last_start = cyc;
            exp_q.push_back(e);
            @(negedge clk);
            start  = 1'b0;
            keylen = 2'($urandom_range(0, 3));
            @(negedge clk);
            block_msg = {$urandom(), $urandom(), $urandom(), $urandom()};
        endtask

        task automatic wait_until(input int unsigned t);
            int n;
            n = 0;
            while (cyc < t && n < 400) begin
                @(negedge clk);
                n++;
            end
        endtask

        task automatic wait_idle();
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 400) begin
                @(negedge clk);
                n++;
            end
            if (exp_q.size() != 0) begin
                check_output(LANES, "idle timeout", 128'(exp_q.size()), 128'd0);
                exp_q.delete();
            end
        endtask

        task automatic ignored_start(input int unsigned t);
            wait_until(t);
            start     = 1'b1;
            keylen    = 2'($urandom_range(0, 3));
            block_msg = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
            start = 1'b0;
        endtask

        initial begin
            logic [255:0] key;
            logic [127:0] pt;
            logic [1:0]   kl;
            int unsigned  dur;
            start    = 1'b0;
            abort    = 1'b0;
            keylen   = 2'b00;
            block_msg = '0;
            rk_cur   = '0;
            hold_val = '0;
            last_due = 0;
            last_start = 0;

            @(negedge clk);
            check_output(LANES, "reset ready", 128'(ready), 128'd1);
            check_output(LANES, "reset done", 128'(done), 128'd0);
            check_output(LANES, "reset keylen_err", 128'(keylen_err), 128'd0);
            check_output(LANES, "reset round", 128'(round), 128'd0);
            check_output(LANES, "reset new_block", new_block, 128'd0);
            check_output(LANES, "reset sboxw", 128'(sboxw), 128'd0);
            wait (reset_n === 1'b1);
            @(negedge clk);

            start  = 1'b1;
            keylen = 2'b11;
            @(negedge clk);
            check_output(LANES, "keylen_err pulse", 128'(keylen_err), 128'd1);
            check_output(LANES, "keylen_err ready", 128'(ready), 128'd1);
            check_output(LANES, "keylen_err round", 128'(round), 128'd0);
            start  = 1'b0;
            keylen = 2'b00;
            @(negedge clk);
            check_output(LANES, "keylen_err width", 128'(keylen_err), 128'd0);
            check_output(LANES, "keylen_err idle", 128'(ready), 128'd1);

            start = 1'b1;
            abort = 1'b1;
            @(negedge clk);
            check_output(LANES, "abort beats start", 128'(ready), 128'd1);
            start = 1'b0;
            abort = 1'b0;
            @(negedge clk);

            apply_stimulus(KEY128, 2'b00, PT, CT128);
            wait_until(last_due);
            apply_stimulus(KEY192, 2'b01, PT, CT192);
            ignored_start(last_start + 5);
            wait_until(last_due);
            apply_stimulus(KEY256, 2'b10, PT, CT256);
            wait_idle();
            @(negedge clk);

            key = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            apply_stimulus(key, 2'b00, PT, encrypt(key, 2'b00, PT));
            wait_until(last_start + 20);
            abort = 1'b1;
            exp_q.delete();
            hold_val = '0;
            @(negedge clk);
            abort = 1'b0;
            check_output(LANES, "abort ready", 128'(ready), 128'd1);
            check_output(LANES, "abort new_block", new_block, 128'd0);
            check_output(LANES, "abort round", 128'(round), 128'd0);
            check_output(LANES, "abort no done", 128'(done), 128'd0);
            apply_stimulus(KEY128, 2'b00, PT, CT128);
            wait_idle();

            for (int i = 0; i < 8; i++) begin
                kl  = 2'($urandom_range(0, 2));
                key = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
                pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
                if ($urandom_range(0, 1) == 1) begin
                    wait_until(last_due);
                end else begin
                    wait_idle();
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                apply_stimulus(key, kl, pt, encrypt(key, kl, pt));
                dur = 2 + nr_for(kl) * (SUBS + 1);
                if ($urandom_range(0, 1) == 1)
                    ignored_start(last_start + $urandom_range(3, dur - 2));
            end
            wait_idle();
            repeat (2) @(negedge clk);
            fin[g] = 1'b1;
        end
    end

    // Reset, then wait for every instance to finish under a cycle cap.
    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        while (!(fin[0] && fin[1] && fin[2]) && cyc < 30000) @(negedge clk);
        if (!(fin[0] && fin[1] && fin[2])) begin
            checks++;
            errors++;
            $display("[TB] FAIL watchdog: finished=%0d%0d%0d required=111", fin[0], fin[1], fin[2]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
